tff_reg_arbiter: RTL and testbench
==================================

Name: tff_reg_arbiter

Overview:
- Shared WIDTH-bit register built from T flip-flops, written by two requesters through a round-robin arbiter.
- Each granted transaction is either a D-style load (target value) or a toggle mask.
- The controller converts loads into a toggle vector (t = data ^ q), applies it for one cycle, then checks the result.
- Sits between the flip-flop conversion cells and any logic that needs a shared, arbitrated state register.

Parameters:
- WIDTH, 4, number of T flip-flop cells in the shared register (1..16).

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  requester 0 transaction request (level)
- op0  input  1  requester 0 operation: 0 = load data0, 1 = toggle by mask data0
- data0  input  WIDTH  requester 0 load value or toggle mask
- req1  input  1  requester 1 transaction request (level)
- op1  input  1  requester 1 operation, encoded as op0
- data1  input  WIDTH  requester 1 load value or toggle mask
- gnt0  output  1  requester 0 owns the register
- gnt1  output  1  requester 1 owns the register
- done  output  1  one-cycle pulse: granted transaction complete
- err  output  1  one-cycle pulse with done: q != expected after apply
- busy  output  1  FSM not in IDLE
- q  output  WIDTH  register contents
- qb  output  WIDTH  bitwise complement of q, always

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: q=0, qb=all ones, gnt0=gnt1=0, done=0, err=0, busy=0, state=IDLE, rr pointer=0 (requester 0 preferred).
- Reset asserted mid-transaction aborts it immediately. No done is issued, and q returns to 0.
- FSM states are IDLE, APPLY, CHECK.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: grant that requester.
  - Both req high: grant the requester indicated by the rr pointer.
  - On grant: latch op, data and the requester id; compute expected = op ? (q ^ data) : data; go to APPLY.
- APPLY:
  - gntN=1, busy=1.
  - Drive the cell toggle vector t = op ? data_latched : (data_latched ^ q) for exactly this cycle.
  - q updates at the closing edge.
  - Go to CHECK.
- CHECK:
  - gntN=1, busy=1, done=1, err = (q != expected).
  - Set rr pointer = the other requester.
  - Go to IDLE.
- Cells hold their value (t=0) in every state except APPLY.
- Latency: req sampled high at edge E0 → gnt high in cycle E0..E1, q new value after E1, done in cycle E1..E2, IDLE at E2. Transaction period is 3 cycles.
- Handshake:
  - req is level-sensitive; data/op are captured only at the grant edge and may change afterwards.
  - A requester that wants a single transaction deasserts req before the edge that follows done.
  - If req is still high at that edge, it is a new transaction, subject to round-robin against the other requester.
- Fairness: with both req held high continuously, grants alternate 0,1,0,1…
- A load whose data equals q yields t=0, q unchanged, done=1, err=0.
- A toggle mask of 0 is likewise a legal no-op transaction.
- qb is derived combinationally from q, so qb == ~q in every cycle, including during reset.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE, ST_APPLY, ST_CHECK;
  - op encoding OP_LOAD=0, OP_TOGGLE=1.
- One sub-module, tff_cell:
  - single T flip-flop with async active-low reset;
  - ports clk, rst_n, t, q, qb;
  - instantiated WIDTH times via generate.
- Arbiter and FSM stay in the top module.

Test Plan:
- Reset: rst_n=0 for 2 cycles, WIDTH=4 → q=4'h0, qb=4'hF, gnt0=gnt1=0, busy=0, done=0.
- Single load: req0=1, op0=0, data0=4'hA for one grant → gnt0 high 2 cycles, done at cycle 2, q=4'hA, qb=4'h5, err=0.
- Toggle: from q=4'hA, req1=1, op1=1, data1=4'h3 → gnt1, done, q=4'h9, gnt0 stays 0.
- Contention: req0=req1=1 held, loads 4'h1 and 4'h2 → grant order 0,1,0,1 starting at requester 0 after reset; q alternates 1,2,1,2; done every 3rd cycle.
- No-op: q=4'h9, load 4'h9 → done=1, err=0, q unchanged; toggle mask 0 → same result.
- Mid-operation reset: assert rst_n=0 during APPLY of load 4'hF → q=0 asynchronously, no done pulse, busy=0, next grant after release goes to requester 0.

Source files
------------

// File: rtl/tff_reg_arbiter_pkg.sv
// Shared encodings for the T-flip-flop register arbiter: FSM states and
// transaction opcodes.
package tff_reg_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    localparam logic OP_LOAD   = 1'b0;
    localparam logic OP_TOGGLE = 1'b1;

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: inverts its state on a rising edge when t is high.
// qb is always the complement of q, including while reset is held.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q,
    output logic qb
);

    logic q_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg <= 1'b0;
        end else if (t) begin
            q_reg <= ~q_reg;
        end
    end

    assign q  = q_reg;
    assign qb = ~q_reg;

endmodule

// File: rtl/tff_reg_arbiter.sv
// Shared WIDTH-bit T-flip-flop register written by two requesters through a
// round-robin arbiter; loads are turned into toggle vectors and verified.
module tff_reg_arbiter
    import tff_reg_arbiter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             op0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic             op1,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done,
    output logic             err,
    output logic             busy,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    state_t           state_reg;
    logic             rr_reg;
    logic             id_reg;
    logic             op_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] expected_reg;
    logic             gnt0_reg;
    logic             gnt1_reg;
    logic             done_reg;
    logic             busy_reg;

    logic [WIDTH-1:0] q_int;
    logic [WIDTH-1:0] qb_int;
    logic [WIDTH-1:0] t_vec;

    logic             grant_valid;
    logic             grant_id;
    logic             grant_op;
    logic [WIDTH-1:0] grant_data;

    // rr_reg names the requester that wins when both ask at once.
    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = (req0 && req1) ? rr_reg : req1;
        grant_op    = grant_id ? op1 : op0;
        grant_data  = grant_id ? data1 : data0;
    end

    // Cells only see a nonzero toggle vector during the single APPLY cycle.
    always_comb begin
        t_vec = '0;
        if (state_reg == ST_APPLY) begin
            t_vec = (op_reg == OP_TOGGLE) ? data_reg : (data_reg ^ q_int);
        end
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_cell u_cell (
                .clk   (clk),
                .rst_n (rst_n),
                .t     (t_vec[gi]),
                .q     (q_int[gi]),
                .qb    (qb_int[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_reg       <= 1'b0;
            id_reg       <= 1'b0;
            op_reg       <= OP_LOAD;
            data_reg     <= '0;
            expected_reg <= '0;
            gnt0_reg     <= 1'b0;
            gnt1_reg     <= 1'b0;
            done_reg     <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        id_reg       <= grant_id;
                        op_reg       <= grant_op;
                        data_reg     <= grant_data;
                        expected_reg <= (grant_op == OP_TOGGLE) ? (q_int ^ grant_data) : grant_data;
                        gnt0_reg     <= ~grant_id;
                        gnt1_reg     <= grant_id;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    done_reg  <= 1'b1;
                    state_reg <= ST_CHECK;
                end
                ST_CHECK: begin
                    rr_reg    <= ~id_reg;
                    gnt0_reg  <= 1'b0;
                    gnt1_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    gnt0_reg  <= 1'b0;
                    gnt1_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // err compares the actual cell contents, so a misbehaving cell is caught.
    assign err  = done_reg && (q_int != expected_reg);
    assign gnt0 = gnt0_reg;
    assign gnt1 = gnt1_reg;
    assign done = done_reg;
    assign busy = busy_reg;
    assign q    = q_int;
    assign qb   = qb_int;

endmodule

// File: tb/tb_tff_reg_arbiter.sv
// Directed bench for tff_reg_arbiter: inputs change and outputs are sampled
// on the falling clock edge, away from the rising edge where state updates.
module tb_tff_reg_arbiter;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             req0;
    logic             op0;
    logic [WIDTH-1:0] data0;
    logic             req1;
    logic             op1;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             done;
    logic             err;
    logic             busy;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;

    int compared   = 0;
    int mismatched = 0;

    tff_reg_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0),
        .op0   (op0),
        .data0 (data0),
        .req1  (req1),
        .op1   (op1),
        .data1 (data1),
        .gnt0  (gnt0),
        .gnt1  (gnt1),
        .done  (done),
        .err   (err),
        .busy  (busy),
        .q     (q),
        .qb    (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; op0 = 1'b0; data0 = '0;
        req1 = 1'b0; op1 = 1'b0; data1 = '0;

        // Reset state
        tick();
        tick();
        chk("rst_q", q, 4'h0);
        chk("rst_qb", qb, 4'hF);
        chk("rst_gnt0", gnt0, 1'b0);
        chk("rst_gnt1", gnt1, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        $display("txn reset: q=%0h qb=%0h", q, qb);
        rst_n = 1'b1;

        // Single load of 4'hA by requester 0
        req0 = 1'b1; op0 = 1'b0; data0 = 4'hA;
        tick();
        chk("ld_apply_gnt0", gnt0, 1'b1);
        chk("ld_apply_gnt1", gnt1, 1'b0);
        chk("ld_apply_busy", busy, 1'b1);
        chk("ld_apply_done", done, 1'b0);
        req0 = 1'b0; data0 = 4'h0;
        tick();
        chk("ld_check_gnt0", gnt0, 1'b1);
        chk("ld_check_done", done, 1'b1);
        chk("ld_check_err", err, 1'b0);
        chk("ld_check_q", q, 4'hA);
        chk("ld_check_qb", qb, 4'h5);
        tick();
        chk("ld_idle_busy", busy, 1'b0);
        chk("ld_idle_done", done, 1'b0);
        chk("ld_idle_gnt0", gnt0, 1'b0);
        $display("txn load0 A: q=%0h", q);

        // Toggle 4'hA by mask 4'h3 from requester 1
        req1 = 1'b1; op1 = 1'b1; data1 = 4'h3;
        tick();
        chk("tg_apply_gnt1", gnt1, 1'b1);
        chk("tg_apply_gnt0", gnt0, 1'b0);
        req1 = 1'b0;
        tick();
        chk("tg_check_done", done, 1'b1);
        chk("tg_check_gnt0", gnt0, 1'b0);
        chk("tg_check_q", q, 4'h9);
        chk("tg_check_err", err, 1'b0);
        tick();
        chk("tg_idle_busy", busy, 1'b0);
        $display("txn toggle1 3: q=%0h", q);

        // No-op load of the current value
        req0 = 1'b1; op0 = 1'b0; data0 = 4'h9;
        tick();
        req0 = 1'b0;
        tick();
        chk("nold_done", done, 1'b1);
        chk("nold_err", err, 1'b0);
        chk("nold_q", q, 4'h9);
        tick();
        $display("txn noop load 9: q=%0h", q);

        // No-op toggle with a zero mask
        req1 = 1'b1; op1 = 1'b1; data1 = 4'h0;
        tick();
        chk("notg_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        tick();
        chk("notg_done", done, 1'b1);
        chk("notg_err", err, 1'b0);
        chk("notg_q", q, 4'h9);
        tick();
        $display("txn noop toggle 0: q=%0h", q);

        // Contention after a fresh reset: grants alternate starting at 0
        rst_n = 1'b0;
        tick();
        chk("ct_rst_q", q, 4'h0);
        rst_n = 1'b1;
        req0 = 1'b1; op0 = 1'b0; data0 = 4'h1;
        req1 = 1'b1; op1 = 1'b0; data1 = 4'h2;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ct_gnt0", gnt0, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk("ct_gnt1", gnt1, (k % 2 == 1) ? 1'b1 : 1'b0);
            chk("ct_apply_done", done, 1'b0);
            tick();
            chk("ct_done", done, 1'b1);
            chk("ct_q", q, (k % 2 == 0) ? 4'h1 : 4'h2);
            chk("ct_err", err, 1'b0);
            tick();
            chk("ct_idle_done", done, 1'b0);
            chk("ct_idle_busy", busy, 1'b0);
            $display("txn contention %0d: q=%0h", k, q);
        end
        req0 = 1'b0; req1 = 1'b0;

        // Requester 0 completes a load so the pointer now favours requester 1
        req0 = 1'b1; data0 = 4'h5;
        tick();
        req0 = 1'b0;
        tick();
        chk("pre_q", q, 4'h5);
        tick();
        $display("txn load0 5: q=%0h", q);

        // Reset during APPLY of a load of 4'hF aborts the transaction
        req1 = 1'b1; op1 = 1'b0; data1 = 4'hF;
        tick();
        chk("mr_apply_gnt1", gnt1, 1'b1);
        req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_q", q, 4'h0);
        chk("mr_qb", qb, 4'hF);
        chk("mr_busy", busy, 1'b0);
        chk("mr_gnt1", gnt1, 1'b0);
        chk("mr_done", done, 1'b0);
        tick();
        chk("mr_hold_done", done, 1'b0);
        chk("mr_hold_q", q, 4'h0);
        rst_n = 1'b1;
        req0 = 1'b1; op0 = 1'b1; data0 = 4'h6;
        req1 = 1'b1; op1 = 1'b1; data1 = 4'h3;
        tick();
        chk("mr_next_gnt0", gnt0, 1'b1);
        chk("mr_next_gnt1", gnt1, 1'b0);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        chk("mr_next_q", q, 4'h6);
        chk("mr_next_done", done, 1'b1);
        tick();
        $display("txn after reset toggle0 6: q=%0h", q);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
